// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to count WIDTH serial steps (0 .. WIDTH-1); WIDTH >= 2 keeps this >= 1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: x - y - bin producing a difference bit and a borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, LSB first, one bit per clock,
// with ready/valid handshakes on operand start and result delivery.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_sr_next;
    logic             borrow_q;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    count;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    assign start_ready = (state_reg == IDLE);
    assign done_valid  = (state_reg == DONE);
    assign accept      = start_valid && start_ready;
    assign last_bit    = (state_reg == SHIFT) && (count == LAST);
    // Result bits enter at the top so that after WIDTH shifts bit 0 lands at the LSB.
    assign d_sr_next   = {cell_d, d_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)     state_next = SHIFT;
            SHIFT:   if (last_bit)   state_next = DONE;
            DONE:    if (done_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            borrow_q <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            count    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            borrow_q <= bin;
            a_msb    <= a_in[WIDTH-1];
            b_msb    <= b_in[WIDTH-1];
            count    <= '0;
        end else if (state_reg == SHIFT) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            d_sr     <= d_sr_next;
            borrow_q <= cell_bo;
            count    <= count + 1'b1;
            if (last_bit) begin
                diff <= d_sr_next;
                bout <= cell_bo;
                zero <= (d_sr_next == '0);
                // Signed overflow only possible when operand signs differ.
                ovf  <= (a_msb != b_msb) && (d_sr_next[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             bin = 1'b0;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .bin         (bin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff        (diff),
        .bout        (bout),
        .ovf         (ovf),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Present operands at a falling edge; returns just after the accept edge's following negedge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic keep);
        a_in = a;
        b_in = b;
        bin = bi;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) start_valid = 1'b0;
    endtask

    // Counts clock edges from the accept edge until done_valid is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic bo,
                                input logic ov, input logic z);
        check({tag, ".diff"}, 32'(diff), 32'(d));
        check({tag, ".bout"}, 32'(bout), 32'(bo));
        check({tag, ".ovf"},  32'(ovf),  32'(ov));
        check({tag, ".zero"}, 32'(zero), 32'(z));
    endtask

    task automatic consume(input string tag);
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check({tag, ".done_cleared"}, 32'(done_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(start_ready), 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic bi, input logic [7:0] d, input logic bo,
                           input logic ov, input logic z);
        int n;
        start_op(a, b, bi, 1'b0);
        check({tag, ".busy"}, 32'(start_ready), 32'd0);
        wait_done(n);
        check({tag, ".latency"}, 32'(n), 32'(WIDTH));
        check_result(tag, d, bo, ov, z);
        consume(tag);
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        check("rst.start_ready", 32'(start_ready), 32'd1);
        check("rst.done_valid", 32'(done_valid), 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        full_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        full_op("t2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        full_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        full_op("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        full_op("t4", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure with start_valid held and new operands waiting
        start_op(8'h05, 8'h03, 1'b0, 1'b1);
        a_in = 8'h20;
        b_in = 8'h01;
        wait_done(n);
        check("t5.latency", 32'(n), 32'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5.hold%0d.valid", i), 32'(done_valid), 32'd1);
            check($sformatf("t5.hold%0d.ready", i), 32'(start_ready), 32'd0);
            check($sformatf("t5.hold%0d.diff", i), 32'(diff), 32'h02);
            check($sformatf("t5.hold%0d.flags", i), 32'({bout, ovf, zero}), 32'd0);
            @(negedge clk);
        end
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check("t5.idle.ready", 32'(start_ready), 32'd1);
        check("t5.idle.valid", 32'(done_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        check("t5.accepted", 32'(start_ready), 32'd0);
        wait_done(n);
        check("t5b.latency", 32'(n), 32'(WIDTH));
        check_result("t5b", 8'h1F, 1'b0, 1'b0, 1'b0);
        consume("t5b");

        // Mid-operation asynchronous reset, with non-zero flags left from the prior result
        full_op("t6pre", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        start_op(8'h05, 8'h03, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.async.start_ready", 32'(start_ready), 32'd1);
        check("t6.async.done_valid", 32'(done_valid), 32'd0);
        check_result("t6.async", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6.no_done", 32'(done_valid), 32'd0);
        check("t6.release.ready", 32'(start_ready), 32'd1);
        full_op("t6post", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: accepts two WIDTH-bit operands and a borrow-in over a ready/valid start handshake.
- Computes a - b - bin LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- Presents the result over a ready/valid done handshake.
- Serves as the area-minimal counterpart to the combinational adder cells in the arithmetic library, for datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start_valid, input, 1, operands are presented.
- start_ready, output, 1, block can accept operands.
- a_in, input, WIDTH, minuend.
- b_in, input, WIDTH, subtrahend.
- bin, input, 1, initial borrow-in.
- done_valid, output, 1, result is available.
- done_ready, input, 1, consumer accepts the result.
- diff, output, WIDTH, a - b - bin modulo 2^WIDTH.
- bout, output, 1, final borrow; 1 when unsigned a < b + bin.
- ovf, output, 1, signed overflow.
- zero, output, 1, diff == 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state = IDLE. start_ready = 1 and done_valid = 0. diff, bout, ovf and zero = 0. Shift registers, borrow flop and counter are cleared.
- Asserting rst_n low mid-operation aborts immediately and asynchronously. No done_valid is produced for the aborted operation.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready, capture a_in, b_in and bin into a_sr, b_sr and borrow_q.
  - Capture a_in[WIDTH-1] and b_in[WIDTH-1] into a_msb and b_msb.
  - Set count = 0 and go to SHIFT.
- SHIFT:
  - start_ready = 0.
  - Each edge, the full-subtractor cell computes (d, bo) from a_sr[0], b_sr[0] and borrow_q.
  - d shifts into the MSB of d_sr (right shift). a_sr and b_sr shift right. borrow_q <= bo. count++.
  - On the edge where count == WIDTH-1, go to DONE and load the output registers:
    - diff <= final d_sr.
    - bout <= final bo.
    - zero <= (final d_sr == 0).
    - ovf <= (a_msb != b_msb) && (final diff MSB != a_msb).
- DONE:
  - done_valid = 1 and start_ready = 0.
  - Outputs are stable while done_ready = 0.
  - On done_ready, go to IDLE and deassert done_valid.
  - diff, bout, ovf and zero hold their value until the next result is loaded.
- Latency: done_valid rises exactly WIDTH cycles after the start accept edge. Throughput is one operation per WIDTH+2 cycles.
- Simultaneous events:
  - start_valid asserted in SHIFT or DONE is ignored; there is no queueing.
  - done_ready together with start_valid in DONE: the result is consumed, and the start is accepted no earlier than the following IDLE cycle.
- done_ready asserted while done_valid = 0 has no effect.
- Counter width is $clog2(WIDTH). Wrap-around never occurs because the counter is reset on each accept.
- a_in, b_in and bin are sampled only on the accept edge. Later changes to them have no effect.

Decomposition:
- Shared arithmetic package holds:
  - the state encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - a function or constant for counter width derived from WIDTH.
- Sub-module full_subtractor (combinational), ports x, y, bin, diff, bout:
  - diff = x ^ y ^ bin;
  - bout = (~x & y) | (~(x ^ y) & bin).
- It is instantiated once in the datapath.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, zero=0. done_valid rises exactly 8 cycles after the accept edge.
2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0, zero=0.
3. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
4. a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0, ovf=0.
5. Backpressure: hold done_ready=0 for 5 cycles after done_valid rises, with start_valid=1 and new operands throughout. Required: done_valid, diff and flags stay stable; start_ready=0. After done_ready: one IDLE cycle, then the new operands are accepted.
6. Mid-operation reset: drive rst_n low 4 cycles into SHIFT. Required: all outputs go to reset values without waiting for a clock edge. start_ready=1 after release, and a following a=0x05, b=0x03 operation yields diff=0x02.
